// File: rtl/kbd_pkg.sv
// Shared scan-code constants, letter lookup and prefix-state encoding for the
// keyboard command decoder.
package kbd_pkg;

    localparam logic [7:0] SC_E0    = 8'hE0;
    localparam logic [7:0] SC_F0    = 8'hF0;
    localparam logic [7:0] SC_ENTER = 8'h5A;
    localparam logic [7:0] SC_END   = 8'h69;
    localparam logic [7:0] SC_DEL   = 8'h71;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_GOT_E0   = 2'd1,
        ST_GOT_F0   = 2'd2,
        ST_GOT_E0F0 = 2'd3
    } pfx_state_t;

    // Returns {hit, idx} with idx A=0 .. Z=25 for set-2 letter make codes.
    function automatic logic [5:0] letter_lookup(input logic [7:0] code);
        logic [5:0] r;
        r = 6'd0;
        case (code)
            8'h1C: r = {1'b1, 5'd0};
            8'h32: r = {1'b1, 5'd1};
            8'h21: r = {1'b1, 5'd2};
            8'h23: r = {1'b1, 5'd3};
            8'h24: r = {1'b1, 5'd4};
            8'h2B: r = {1'b1, 5'd5};
            8'h34: r = {1'b1, 5'd6};
            8'h33: r = {1'b1, 5'd7};
            8'h43: r = {1'b1, 5'd8};
            8'h3B: r = {1'b1, 5'd9};
            8'h42: r = {1'b1, 5'd10};
            8'h4B: r = {1'b1, 5'd11};
            8'h3A: r = {1'b1, 5'd12};
            8'h31: r = {1'b1, 5'd13};
            8'h44: r = {1'b1, 5'd14};
            8'h4D: r = {1'b1, 5'd15};
            8'h15: r = {1'b1, 5'd16};
            8'h2D: r = {1'b1, 5'd17};
            8'h1B: r = {1'b1, 5'd18};
            8'h2C: r = {1'b1, 5'd19};
            8'h3C: r = {1'b1, 5'd20};
            8'h2A: r = {1'b1, 5'd21};
            8'h1D: r = {1'b1, 5'd22};
            8'h22: r = {1'b1, 5'd23};
            8'h35: r = {1'b1, 5'd24};
            8'h1A: r = {1'b1, 5'd25};
            default: r = 6'd0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/ps2_rx_frame.sv
// PS/2 frame receiver: synchronizes the raw lines, shifts in 11-bit frames on
// falling clock edges, checks framing/parity and aborts stalled frames.
module ps2_rx_frame #(
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_dat,
    output logic       byte_valid,
    output logic [7:0] rx_byte,
    output logic       frame_err
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic             clk_s1, clk_s2, clk_s3;
    logic             dat_s1, dat_s2;
    logic             fall;
    logic [3:0]       bit_cnt;
    logic [9:0]       shift;
    logic [CNT_W-1:0] idle_cnt;

    assign fall = clk_s3 & ~clk_s2;

    always_ff @(posedge clk) begin
        if (reset) begin
            // Idle PS/2 lines are high; resetting the syncs high avoids a
            // phantom falling edge right after reset.
            clk_s1     <= 1'b1;
            clk_s2     <= 1'b1;
            clk_s3     <= 1'b1;
            dat_s1     <= 1'b1;
            dat_s2     <= 1'b1;
            bit_cnt    <= 4'd0;
            shift      <= 10'd0;
            idle_cnt   <= '0;
            byte_valid <= 1'b0;
            rx_byte    <= 8'd0;
            frame_err  <= 1'b0;
        end else begin
            clk_s1     <= ps2_clk;
            clk_s2     <= clk_s1;
            clk_s3     <= clk_s2;
            dat_s1     <= ps2_dat;
            dat_s2     <= dat_s1;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;

            if (fall) begin
                idle_cnt <= CNT_W'(TIMEOUT_CYCLES);
                if (bit_cnt == 4'd10) begin
                    bit_cnt <= 4'd0;
                    // shift[0]=start, shift[8:1]=data, shift[9]=parity, dat_s2=stop
                    if (!shift[0] && (^shift[9:1]) && dat_s2) begin
                        byte_valid <= 1'b1;
                        rx_byte    <= shift[8:1];
                    end else begin
                        frame_err <= 1'b1;
                    end
                end else begin
                    shift   <= {dat_s2, shift[9:1]};
                    bit_cnt <= bit_cnt + 4'd1;
                end
            end else if (bit_cnt != 4'd0) begin
                if (idle_cnt <= CNT_W'(1)) begin
                    bit_cnt   <= 4'd0;
                    frame_err <= 1'b1;
                end else begin
                    idle_cnt <= idle_cnt - CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/kbd_command_decoder.sv
// Turns PS/2 scan-code set 2 bytes into single-cycle command pulses and a
// letter code, tracking E0/F0 prefixes and suppressing typematic repeats.
//
//   state       | meaning
//   ST_IDLE     | no prefix pending
//   ST_GOT_E0   | extended prefix seen, next byte is an extended make or F0
//   ST_GOT_F0   | break prefix seen, next byte is a plain break
//   ST_GOT_E0F0 | extended break prefix seen, next byte is an extended break
module kbd_command_decoder
    import kbd_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_dat,
    output logic       load,
    output logic       try,
    output logic       endinput,
    output logic       start,
    output logic       wipe,
    output logic [4:0] letter,
    output logic       frame_err
);

    logic       byte_valid;
    logic [7:0] rx_byte;
    logic       rx_err;
    pfx_state_t state;
    logic [8:0] held_key;
    logic [8:0] key;
    logic       key_ext;
    logic       is_make;
    logic       is_break;
    logic [5:0] lk;

    ps2_rx_frame #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_rx (
        .clk       (clk),
        .reset     (reset),
        .ps2_clk   (ps2_clk),
        .ps2_dat   (ps2_dat),
        .byte_valid(byte_valid),
        .rx_byte   (rx_byte),
        .frame_err (rx_err)
    );

    assign frame_err = rx_err;
    assign lk        = letter_lookup(rx_byte);
    assign key       = {key_ext, rx_byte};

    always_comb begin
        key_ext  = 1'b0;
        is_make  = 1'b0;
        is_break = 1'b0;
        if (byte_valid && !rx_err) begin
            case (state)
                ST_IDLE:     is_make = (rx_byte != SC_E0) && (rx_byte != SC_F0);
                ST_GOT_E0: begin
                    key_ext = 1'b1;
                    is_make = (rx_byte != SC_F0);
                end
                ST_GOT_F0:   is_break = 1'b1;
                ST_GOT_E0F0: begin
                    key_ext  = 1'b1;
                    is_break = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            held_key <= 9'd0;
            load     <= 1'b0;
            try      <= 1'b0;
            endinput <= 1'b0;
            start    <= 1'b0;
            wipe     <= 1'b0;
            letter   <= 5'd0;
        end else begin
            load     <= 1'b0;
            try      <= 1'b0;
            endinput <= 1'b0;
            start    <= 1'b0;
            wipe     <= 1'b0;

            if (rx_err) begin
                state <= ST_IDLE;
            end else if (byte_valid) begin
                case (state)
                    ST_IDLE: begin
                        if (rx_byte == SC_E0)      state <= ST_GOT_E0;
                        else if (rx_byte == SC_F0) state <= ST_GOT_F0;
                    end
                    ST_GOT_E0: state <= (rx_byte == SC_F0) ? ST_GOT_E0F0 : ST_IDLE;
                    default:   state <= ST_IDLE;
                endcase
            end

            // A make matching the held key is a typematic repeat.
            if (is_make && key != held_key) begin
                held_key <= key;
                if (!key_ext && lk[5]) begin
                    letter <= lk[4:0];
                    load   <= 1'b1;
                    try    <= 1'b1;
                end else if (!key_ext && rx_byte == SC_ENTER) begin
                    start <= 1'b1;
                end else if (key_ext && rx_byte == SC_END) begin
                    endinput <= 1'b1;
                end else if (key_ext && rx_byte == SC_DEL) begin
                    wipe <= 1'b1;
                end
            end

            if (is_break && key == held_key) begin
                held_key <= 9'd0;
            end
        end
    end

endmodule

// File: doc/kbd_command_decoder.md
# kbd_command_decoder

Upstream stage of the game controller. Receives raw PS/2 keyboard frames, assembles scan-code set 2 bytes, and tracks E0/F0 prefixes. Translates key presses into the single-cycle command pulses (`load`, `endinput`, `start`, `wipe`, `try`) and the 5-bit letter code that the controller and datapath consume. Suppresses typematic repeats and discards malformed or stalled frames.

## Interface
- `TIMEOUT_CYCLES`, default 50000: max clk cycles between PS/2 falling edges inside a frame before the frame is aborted (1 ms at 50 MHz).
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-high; clears all state.
- `ps2_clk` in 1: raw PS/2 clock, asynchronous.
- `ps2_dat` in 1: raw PS/2 data, asynchronous.
- `load` out 1: 1-cycle pulse on a letter make.
- `try` out 1: 1-cycle pulse on a letter make, coincident with `load`.
- `endinput` out 1: 1-cycle pulse on End make (E0 69).
- `start` out 1: 1-cycle pulse on Enter make (5A).
- `wipe` out 1: 1-cycle pulse on Delete make (E0 71).
- `letter` out 5: last letter decoded, A=0 … Z=25. Holds its value between presses.
- `frame_err` out 1: 1-cycle pulse on parity, start-bit, or stop-bit error, or on timeout.

## Operation
- Reset values: all outputs 0, FSM in IDLE, bit counter 0, held-key register empty.
- Sync: `ps2_clk` and `ps2_dat` each pass through a 2-FF synchronizer. A falling edge of synced `ps2_clk` is detected against a third FF.
- Frame receiver: on each detected falling edge, sample synced `ps2_dat`. Frame is 11 bits: start=0, 8 data LSB-first, odd parity, stop=1.
  - After bit 10, if start, parity and stop are all good: `byte_valid` for 1 cycle with `byte`.
  - Otherwise: `frame_err` pulse and the byte is dropped.
- Timeout: an idle counter reloads on every falling edge. If it reaches `TIMEOUT_CYCLES` while the bit count is nonzero: bit count returns to 0, `frame_err` pulses, and the prefix FSM returns to IDLE.
- Prefix FSM states: IDLE, GOT_E0, GOT_F0, GOT_E0F0. On `byte_valid`:
  - IDLE: E0→GOT_E0; F0→GOT_F0; else plain make → decode, stay IDLE.
  - GOT_E0: F0→GOT_E0F0; else extended make → decode, →IDLE.
  - GOT_F0: plain break → release held key if it matches, →IDLE.
  - GOT_E0F0: extended break → release if it matches, →IDLE.
- Any `frame_err` forces IDLE.
- Repeat suppression: a 9-bit held-key register stores {ext, code}.
  - A make equal to the held key produces no pulse.
  - A make of a different key decodes and replaces the held key.
  - A break of the held key clears the register.
- Decode, applied to makes only:
  - 26 letter codes (set 2: A=1C, B=32, C=21, D=23, E=24, F=2B, G=34, H=33, I=43, J=3B, K=42, L=4B, M=3A, N=31, O=44, P=4D, Q=15, R=2D, S=1B, T=2C, U=3C, V=2A, W=1D, X=22, Y=35, Z=1A): update `letter` and pulse `load` and `try`.
  - 5A → `start`; E0 69 → `endinput`; E0 71 → `wipe`.
  - All other codes are ignored silently, but still update the held-key register.
- Simultaneous events: `frame_err` and a timeout in the same cycle produce one `frame_err` pulse. Only one command pulse is possible per byte.
- Reset mid-frame: the partial frame is discarded. The next start bit is treated as a fresh frame.

## Timing
- Edge-detect cycle N is the clk cycle in which the stop-bit falling edge is detected. That is the 3rd clk after the raw edge, through sync and detect.
- `byte_valid` (internal) fires at N+1.
- Command pulse and `letter` update fire at N+2. `letter` is stable from N+2 onward.
- `frame_err` fires at N+1 for a bad frame. On timeout it fires in the cycle the counter hits `TIMEOUT_CYCLES`.
- Every output pulse is exactly 1 clk wide. Each qualifying byte produces at most one pulse.
- Minimum throughput: one byte per PS/2 frame, with no back-pressure. The controller must accept each pulse in the same cycle it occurs.

## Structure
- Package `kbd_pkg`:
  - scan-code constants: E0, F0, 5A, 69, 71;
  - the 26-entry letter scan-code mapping, as a function returning {hit, idx[4:0]};
  - prefix FSM state encoding.
- Sub-module `ps2_rx_frame` contains:
  - the synchronizers and edge detect;
  - the 11-bit shift and bit counter;
  - the parity check and timeout.
- Its outputs are `byte_valid`, `byte[7:0]` and `frame_err`.
- The top level holds the prefix FSM, the held-key register and the decode.

## Test plan
- Frame 1C (good odd parity): `letter`=0, `load`=`try`=1 for exactly 1 cycle at N+2; no other pulse.
- Frames 1C, 1C, 1C, F0, 1C, 1C: exactly two `load`/`try` pulses (first make, and the make after the break).
- Frames E0 69 then E0 F0 69: one `endinput` pulse; E0 71 gives one `wipe`; 5A gives one `start`; 2B gives `letter`=5.
- Frame 32 with the parity bit flipped: `frame_err` pulse at N+1, no `load`; following frame 32 gives `letter`=1 plus a pulse.
- Stall after 4 bits for `TIMEOUT_CYCLES` (set 100 in sim): `frame_err` pulse; next full frame 1A gives `letter`=25.
- Assert `reset` after bit 6 of a frame: all outputs 0; the stale bits are ignored; next frame 44 gives `letter`=14.
